// File: rtl/game_key_pkg.sv
// Shared scan codes, key indices and receive-FSM states for the PS/2 game key block.
package game_key_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_E     = 8'h24;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;

    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_OK   = 2;
    localparam int KEY_ACT  = 3;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_map_t;

    // Arrow codes only count behind E0; letter/Enter codes only without it.
    function automatic key_map_t map_code(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = 2'd0;
        if (ext) begin
            case (code)
                SC_UP:   m.idx = 2'(KEY_UP);
                SC_DOWN: m.idx = 2'(KEY_DOWN);
                default: m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:     m.idx = 2'(KEY_UP);
                SC_S:     m.idx = 2'(KEY_DOWN);
                SC_ENTER: m.idx = 2'(KEY_OK);
                SC_E:     m.idx = 2'(KEY_ACT);
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronisers, ps2_clk glitch filter, 11-bit frame FSM
// with odd-parity/start/stop checking and an inter-edge timeout.
module ps2_rx
    import game_key_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    rx_state_t     state;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [TW-1:0] tmo_cnt;
    logic          frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= clk_filt;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // After ten shifts: [7:0] data, [8] parity, [9] stop.
    assign frame_ok   = (^shift[8:0]) && shift[9];
    assign byte_valid = (state == CHECK) && frame_ok;
    assign byte_data  = shift[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tmo_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            tmo_cnt   <= (state != RECV || fall) ? '0 : tmo_cnt + TW'(1);
            case (state)
                IDLE: begin
                    if (fall && !data_sync[1]) begin
                        state   <= RECV;
                        bit_cnt <= '0;
                        shift   <= '0;
                    end
                end
                RECV: begin
                    if (fall) begin
                        shift <= {data_sync[1], shift[9:1]};
                        if (bit_cnt == 4'd9)
                            state <= CHECK;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        shift     <= '0;
                    end
                end
                CHECK: begin
                    if (!frame_ok)
                        frame_err <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/game_key_ps2.sv
// PS/2 keyboard front end for the game: decodes E0/F0-prefixed scan codes into
// held key levels and rising-edge press pulses.
module game_key_ps2
    import game_key_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [3:0] key_press,
    output logic       frame_err
);

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       ext;
    logic       brk;
    key_map_t   km;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign km = map_code(byte_data, ext);

    // Prefix flags survive bad frames; a make of an already-held key raises no pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key       <= '0;
            key_press <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
        end else begin
            key_press <= '0;
            if (byte_valid) begin
                if (byte_data == SC_EXT) begin
                    ext <= 1'b1;
                end else if (byte_data == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (km.hit) begin
                        if (brk) begin
                            key[km.idx] <= 1'b0;
                        end else begin
                            key[km.idx]       <= 1'b1;
                            key_press[km.idx] <= ~key[km.idx];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_key_ps2.sv
// Directed bench for game_key_ps2: a table of scan-code frames with expected key state,
// plus hand-written timeout, glitch and mid-frame reset sequences.
module tb_game_key_ps2;

    localparam int HALF = 20;
    localparam int TMO  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key;
    logic [3:0] key_press;
    logic       frame_err;

    typedef struct {
        logic [7:0] code;
        logic       bad;
        logic [3:0] key;
        logic [3:0] press;
        int         err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   press_tot[4];
    int   err_tot = 0;

    game_key_ps2 #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key       (key),
        .key_press (key_press),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 4; i++) press_tot[i] = 0;

    always @(negedge clk) begin
        for (int b = 0; b < 4; b++)
            if (key_press[b]) press_tot[b] = press_tot[b] + 1;
        if (frame_err) err_tot = err_tot + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mkFrame(input logic [7:0] code, input logic bad);
        return {1'b1, (~^code) ^ bad, code, 1'b0};
    endfunction

    task automatic sendBits(input logic [10:0] bits, input int nbits, input int glitch_after);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
            if (i == glitch_after) begin
                tick(HALF / 2);
                ps2_clk = 1'b0;
                tick(4);
                ps2_clk = 1'b1;
            end
        end
        ps2_data = 1'b1;
    endtask

    task automatic addVec(input logic [7:0] code, input logic bad, input logic [3:0] k,
                          input logic [3:0] p, input int e);
        vec_t v;
        v.code = code; v.bad = bad; v.key = k; v.press = p; v.err = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input string name, input logic [7:0] code, input logic bad,
                                 input int glitch_after, input logic [3:0] exp_key,
                                 input logic [3:0] exp_press, input int exp_err);
        int         base_p[4];
        int         base_e;
        logic [3:0] mask;
        int         cnt;
        for (int b = 0; b < 4; b++) base_p[b] = press_tot[b];
        base_e = err_tot;
        sendBits(mkFrame(code, bad), 11, glitch_after);
        tick(30);
        mask = '0;
        cnt  = 0;
        for (int b = 0; b < 4; b++) begin
            mask[b] = (press_tot[b] != base_p[b]);
            cnt     = cnt + (press_tot[b] - base_p[b]);
        end
        checkOutput({name, " key"}, 32'(key), 32'(exp_key));
        checkOutput({name, " press_mask"}, 32'(mask), 32'(exp_press));
        checkOutput({name, " press_cycles"}, 32'(cnt), 32'($countones(exp_press)));
        checkOutput({name, " frame_err"}, 32'(err_tot - base_e), 32'(exp_err));
    endtask

    initial begin
        int base_e;

        addVec(8'h1D, 0, 4'b0001, 4'b0001, 0);
        addVec(8'hF0, 0, 4'b0001, 4'b0000, 0);
        addVec(8'h1D, 0, 4'b0000, 4'b0000, 0);
        addVec(8'hE0, 0, 4'b0000, 4'b0000, 0);
        addVec(8'h75, 0, 4'b0001, 4'b0001, 0);
        addVec(8'h75, 0, 4'b0001, 4'b0000, 0);
        addVec(8'hE0, 0, 4'b0001, 4'b0000, 0);
        addVec(8'hF0, 0, 4'b0001, 4'b0000, 0);
        addVec(8'h75, 0, 4'b0000, 4'b0000, 0);
        addVec(8'hE0, 0, 4'b0000, 4'b0000, 0);
        addVec(8'h5A, 0, 4'b0000, 4'b0000, 0);
        addVec(8'h5A, 0, 4'b0100, 4'b0100, 0);
        addVec(8'h5A, 0, 4'b0100, 4'b0000, 0);
        addVec(8'h5A, 0, 4'b0100, 4'b0000, 0);
        addVec(8'hF0, 0, 4'b0100, 4'b0000, 0);
        addVec(8'h5A, 0, 4'b0000, 4'b0000, 0);
        addVec(8'h24, 1, 4'b0000, 4'b0000, 1);
        addVec(8'h24, 0, 4'b1000, 4'b1000, 0);
        addVec(8'hFA, 0, 4'b1000, 4'b0000, 0);
        addVec(8'hE0, 0, 4'b1000, 4'b0000, 0);
        addVec(8'hAA, 1, 4'b1000, 4'b0000, 1);
        addVec(8'h72, 0, 4'b1010, 4'b0010, 0);
        addVec(8'h1D, 0, 4'b1011, 4'b0001, 0);
        addVec(8'hE0, 0, 4'b1011, 4'b0000, 0);
        addVec(8'hF0, 0, 4'b1011, 4'b0000, 0);
        addVec(8'h75, 0, 4'b1010, 4'b0000, 0);
        addVec(8'hE0, 0, 4'b1010, 4'b0000, 0);
        addVec(8'hF0, 0, 4'b1010, 4'b0000, 0);
        addVec(8'h72, 0, 4'b1000, 4'b0000, 0);

        tick(5);
        checkOutput("reset key", 32'(key), 32'h0);
        checkOutput("reset key_press", 32'(key_press), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus($sformatf("v%0d_%02h", i, vecs[i].code), vecs[i].code, vecs[i].bad,
                          -1, vecs[i].key, vecs[i].press, vecs[i].err);

        base_e = err_tot;
        sendBits(mkFrame(8'h1B, 0), 5, -1);
        tick(TMO + 200);
        checkOutput("timeout frame_err", 32'(err_tot - base_e), 32'd1);
        checkOutput("timeout key", 32'(key), 32'b1000);
        applyStimulus("after_timeout_1B", 8'h1B, 0, -1, 4'b1010, 4'b0010, 0);

        base_e = err_tot;
        ps2_data = 1'b0;
        tick(5);
        ps2_clk = 1'b0;
        tick(4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        tick(40);
        checkOutput("idle glitch frame_err", 32'(err_tot - base_e), 32'd0);
        applyStimulus("glitch_F0", 8'hF0, 0, 3, 4'b1010, 4'b0000, 0);
        applyStimulus("glitch_1B", 8'h1B, 0, 6, 4'b1000, 4'b0000, 0);

        sendBits(mkFrame(8'h24, 0), 4, -1);
        rst = 1'b1;
        tick(3);
        checkOutput("midreset key", 32'(key), 32'h0);
        checkOutput("midreset key_press", 32'(key_press), 32'h0);
        checkOutput("midreset frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        tick(5);
        applyStimulus("after_reset_1D", 8'h1D, 0, -1, 4'b0001, 4'b0001, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
